alu_exec_unit: RTL

Multi-cycle 64-bit execute unit that consumes the 4-bit ALU control code produced by the execute-stage ALU control logic, plus two operands, and returns a result and zero flag. It sits in `3_execute` between the ALU control decode and the memory/branch stage. Logical and add/sub operations complete in one cycle; MUL runs a shift-add multiplier. Valid/ready handshakes on both sides let the pipeline stall around the multiplier.

---
 rtl/alu_exec_unit_pkg.sv | 19 +
 rtl/alu_exec_unit_shift_add_mul.sv | 54 +++++
 rtl/alu_exec_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU control codes and execute-unit FSM encoding.
// The code constants must stay in step with the ALU control decode.
package alu_exec_unit_pkg;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_ORR    = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_PASS_B = 4'b0111;
    localparam logic [3:0] ALU_MUL    = 4'b1000;
    localparam logic [3:0] ALU_NOR    = 4'b1100;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StDone = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_shift_add_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low DATA_WIDTH bits of product.
// done/product are combinational on the final iteration so the caller can capture in that cycle.
module shift_add_mul #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);

    logic                  busy_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] mcand_q;
    logic [DATA_WIDTH-1:0] mplier_q;

    always_comb begin
        acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
        done    = busy_q && (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));
        busy    = busy_q;
        product = acc_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_WIDTH'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes; single-cycle logic/add/sub, iterative MUL.
// Result, zero and illegal are registered together and held until the consumer takes them.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  illegal
);

    alu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_ill;
    logic                  mul_start, mul_busy, mul_done;
    logic [DATA_WIDTH-1:0] mul_product;

    shift_add_mul #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        unique case (alu_control)
            ALU_AND:    alu_res = a & b;
            ALU_ORR:    alu_res = a | b;
            ALU_ADD:    alu_res = a + b;
            ALU_SUB:    alu_res = a - b;
            ALU_PASS_B: alu_res = b;
            ALU_NOR:    alu_res = ~(a | b);
            default:    alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        mul_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (alu_control == ALU_MUL) begin
                        mul_start = 1'b1;
                        state_d   = StMul;
                    end else begin
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = alu_ill;
                        state_d   = StDone;
                    end
                end
            end
            StMul: begin
                if (mul_done) begin
                    result_d  = mul_product;
                    zero_d    = (mul_product == '0);
                    illegal_d = 1'b0;
                    state_d   = StDone;
                end else if (!mul_busy) begin
                    // Multiplier lost its operation; recover rather than hang.
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
